// File: rtl/mips_pkg.sv
// Shared constants for the multicycle MIPS control unit.
// Holds opcode/funct encodings of the supported ISA subset, ALU control
// codes, internal aluop codes and the 4-bit FSM state encoding.
package mips_pkg;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  // ALU control codes driven to the ALU
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Internal aluop: FSM -> ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // FSM state encoding; codes 12..15 are unused and recover to FETCH
  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } state_e;

  // True when the opcode belongs to the supported subset
  function automatic logic op_supported(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mc_control_alu_decoder.sv
// ALU control decoder (combinational).
// Ports:
//   aluop_i         2  operation class from the main FSM
//   funct_i         6  R-type funct field
//   alu_ctrl_o      3  ALU operation code
//   funct_illegal_o 1  funct unsupported while aluop selects funct decode
module alu_decoder
  import mips_pkg::*;
(
  input  logic [1:0] aluop_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alu_ctrl_o,
  output logic       funct_illegal_o
);

  always_comb begin
    alu_ctrl_o      = ALU_ADD;
    funct_illegal_o = 1'b0;
    case (aluop_i)
      ALUOP_ADD: alu_ctrl_o = ALU_ADD;
      ALUOP_SUB: alu_ctrl_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct_i)
          F_ADD:   alu_ctrl_o = ALU_ADD;
          F_SUB:   alu_ctrl_o = ALU_SUB;
          F_AND:   alu_ctrl_o = ALU_AND;
          F_OR:    alu_ctrl_o = ALU_OR;
          F_SLT:   alu_ctrl_o = ALU_SLT;
          default: begin
            // Unknown funct still executes as add so ALUWB stays well defined
            alu_ctrl_o      = ALU_ADD;
            funct_illegal_o = 1'b1;
          end
        endcase
      end
      default: alu_ctrl_o = ALU_ADD;  // aluop 11 is never produced
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multicycle MIPS control unit: Moore main FSM plus ALU control decoder.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   op, funct    instruction fields held in the IR from DECODE onward
//   zero         ALU zero flag, used only in BRANCH
//   iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
//   alusrcb[1:0], pcsrc[1:0], pcen  datapath selects / enables
//   alu_ctrl[2:0] ALU operation
//   illegal      one-cycle pulse on unsupported opcode (DECODE) or funct (EXECUTE)
//   state[3:0]   current FSM state for debug
module mc_control
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic [2:0] alu_ctrl,
  output logic       illegal,
  output logic [3:0] state
);

  state_e     state_q, state_d;
  state_e     out_state;
  logic       pcwrite, branch;
  logic       irwrite_raw, memwrite_raw, regwrite_raw;
  logic [1:0] aluop;
  logic       funct_illegal;

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR:  state_d = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   state_d = MEMWB;
      EXECUTE: state_d = ALUWB;
      ADDIEX:  state_d = ADDIWB;
      default: state_d = FETCH;  // write-back states, BRANCH, JUMP, unused codes
    endcase
  end

  // While reset is held the outputs show FETCH values; enables are gated below.
  assign out_state = reset ? FETCH : state_q;

  always_comb begin
    iord         = 1'b0;
    memwrite_raw = 1'b0;
    irwrite_raw  = 1'b0;
    regdst       = 1'b0;
    memtoreg     = 1'b0;
    regwrite_raw = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = 2'b00;
    pcsrc        = 2'b00;
    pcwrite      = 1'b0;
    branch       = 1'b0;
    aluop        = ALUOP_ADD;
    case (out_state)
      FETCH: begin
        irwrite_raw = 1'b1;
        pcwrite     = 1'b1;
        alusrcb     = 2'b01;
      end
      DECODE:  alusrcb = 2'b11;  // precompute branch target into ALUOut
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD:   iord = 1'b1;
      MEMWB: begin
        memtoreg     = 1'b1;
        regwrite_raw = 1'b1;
      end
      MEMWR: begin
        iord         = 1'b1;
        memwrite_raw = 1'b1;
      end
      EXECUTE: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      ALUWB: begin
        regdst       = 1'b1;
        regwrite_raw = 1'b1;
      end
      BRANCH: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      ADDIWB:  regwrite_raw = 1'b1;
      JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  alu_decoder u_alu_decoder (
    .aluop_i         (aluop),
    .funct_i         (funct),
    .alu_ctrl_o      (alu_ctrl),
    .funct_illegal_o (funct_illegal)
  );

  assign irwrite  = irwrite_raw & ~reset;
  assign memwrite = memwrite_raw & ~reset;
  assign regwrite = regwrite_raw & ~reset;
  assign pcen     = (pcwrite | (branch & zero)) & ~reset;
  assign illegal  = ~reset &
                    (((out_state == DECODE) & ~op_supported(op)) |
                     ((out_state == EXECUTE) & funct_illegal));
  assign state    = state_q;

endmodule

// File: tb/tb_mc_control.sv
module tb_mc_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero;
  logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic       pcen;
  logic [2:0] alu_ctrl;
  logic       illegal;
  logic [3:0] state;

  mc_control dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .pcen(pcen), .alu_ctrl(alu_ctrl),
    .illegal(illegal), .state(state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Observed vector: {state, iord, memwrite, irwrite, regdst, memtoreg,
  // regwrite, alusrca, alusrcb, pcsrc, pcen, alu_ctrl, illegal}
  logic [19:0] dut_vec;
  assign dut_vec = {state, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
                    alusrca, alusrcb, pcsrc, pcen, alu_ctrl, illegal};

  // Scoreboard
  logic [19:0] exp_q[$];
  string       name_q[$];
  int          n_vec  = 0;
  int          n_miss = 0;

  function automatic logic [19:0] ev(
    input logic [3:0] st, input logic e_iord, input logic e_mw,
    input logic e_irw, input logic e_rd, input logic e_mtr, input logic e_rw,
    input logic e_asa, input logic [1:0] e_asb, input logic [1:0] e_pcs,
    input logic e_pcen, input logic [2:0] e_alu, input logic e_ill);
    return {st, e_iord, e_mw, e_irw, e_rd, e_mtr, e_rw, e_asa, e_asb, e_pcs,
            e_pcen, e_alu, e_ill};
  endfunction

  // Monitor: one expected vector per cycle, compared mid-cycle
  always @(negedge clk) begin
    logic [19:0] e;
    string       nm;
    if (exp_q.size() != 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_vec++;
      if (dut_vec !== e) begin
        n_miss++;
        $display("FAIL %s: got %05h required %05h", nm, dut_vec, e);
      end
    end
  end

  // Driver: called #1 after a rising edge; queues the expectation for this
  // cycle and advances to the next cycle.
  task automatic cyc(input string nm, input logic [19:0] e);
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  // Hand-written per-state rows
  task automatic r_fetch();
    cyc("fetch", ev(4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b1, 3'b010, 1'b0));
  endtask
  task automatic r_decode(input logic ill);
    cyc("decode", ev(4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0, 3'b010, ill));
  endtask

  task automatic run_lw();
    op = 6'b100011; funct = 6'b000000;
    r_fetch(); r_decode(1'b0);
    cyc("lw_memadr", ev(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 1'b0, 3'b010, 1'b0));
    cyc("lw_memrd",  ev(4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 3'b010, 1'b0));
    cyc("lw_memwb",  ev(4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 3'b010, 1'b0));
  endtask

  task automatic run_sw();
    op = 6'b101011; funct = 6'b000000;
    r_fetch(); r_decode(1'b0);
    cyc("sw_memadr", ev(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 1'b0, 3'b010, 1'b0));
    cyc("sw_memwr",  ev(4'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 3'b010, 1'b0));
  endtask

  task automatic run_r(input logic [5:0] f, input logic [2:0] alu, input logic ill);
    op = 6'b000000; funct = f;
    r_fetch(); r_decode(1'b0);
    cyc("r_execute", ev(4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, alu, ill));
    cyc("r_aluwb",   ev(4'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 3'b010, 1'b0));
  endtask

  task automatic run_beq(input logic z);
    op = 6'b000100; funct = 6'b000000; zero = ~z;
    r_fetch();   // zero must be ignored outside BRANCH
    r_decode(1'b0);
    zero = z;
    cyc("beq_branch", ev(4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, z, 3'b110, 1'b0));
    zero = 1'b0;
  endtask

  task automatic run_addi();
    op = 6'b001000; funct = 6'b111111;
    r_fetch(); r_decode(1'b0);
    cyc("addi_ex", ev(4'd9,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 1'b0, 3'b010, 1'b0));
    cyc("addi_wb", ev(4'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 3'b010, 1'b0));
  endtask

  task automatic run_j();
    op = 6'b000010; funct = 6'b000000;
    r_fetch(); r_decode(1'b0);
    cyc("j_jump", ev(4'd11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 1'b1, 3'b010, 1'b0));
  endtask

  task automatic run_bad_op();
    op = 6'b111111; funct = 6'b000000;
    r_fetch(); r_decode(1'b1);
  endtask

  initial begin
    reset = 1'b1; op = 6'b0; funct = 6'b0; zero = 1'b0;
    @(posedge clk); #1;
    // Reset held: FETCH values with enables forced low
    cyc("reset_1", ev(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 3'b010, 1'b0));
    cyc("reset_2", ev(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 3'b010, 1'b0));
    reset = 1'b0;

    run_lw();
    run_sw();
    run_r(6'b101010, 3'b111, 1'b0);
    run_r(6'b100010, 3'b110, 1'b0);
    run_r(6'b100100, 3'b000, 1'b0);
    run_r(6'b100101, 3'b001, 1'b0);
    run_r(6'b100000, 3'b010, 1'b0);
    run_beq(1'b1);
    run_beq(1'b0);
    run_addi();
    run_j();
    run_bad_op();
    run_r(6'b000111, 3'b010, 1'b1);

    // Reset during MEMWR of sw: store suppressed, outputs show FETCH values
    op = 6'b101011; funct = 6'b000000;
    r_fetch(); r_decode(1'b0);
    cyc("sw_memadr", ev(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 1'b0, 3'b010, 1'b0));
    reset = 1'b1;
    cyc("memwr_reset", ev(4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 3'b010, 1'b0));
    reset = 1'b0;
    r_fetch();
    r_decode(1'b0);

    @(posedge clk); #1;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: got %0d pending required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
